// File: rtl/aes_spi_master.sv
// aes_spi_master: SPI initiator driving the AES core's SPI slave port.
//
// A transfer starts with a one-cycle start pulse. The design captures
// {plaintext, key} and shifts those 256 bits out MSB-first with load high.
// It then waits for done, pauses for HOLD_CYCLES, and clocks the 128-bit
// cyphertext back in MSB-first. valid pulses for one cycle at the end.
//
// Ports:
//   clk, reset         system clock, synchronous active-low reset
//   start              transfer request, sampled only while idle
//   plaintext, key     128-bit operands captured on an accepted start
//   busy               high from accepted start until back in idle
//   valid              one-cycle pulse when cyphertext is complete
//   cyphertext         result, held until the next accepted start
//   sck, sdi, load     SPI clock, serial data out and frame to the core
//   sdo, done          serial data from the core and its completion flag
//   timeout            done-wait watchdog flag (AES_SPI_MASTER_TIMEOUT_EN only)
//
// Optional feature macro: AES_SPI_MASTER_TIMEOUT_EN.
// With the macro defined, a wait for done that lasts TIMEOUT_CYCLES returns
// the design to idle and sets a sticky timeout flag.
module aes_spi_master #(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned HOLD_CYCLES    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         busy,
  output logic         valid,
  output logic [127:0] cyphertext,
  output logic         sck,
  output logic         sdi,
  input  logic         sdo,
  output logic         load,
  input  logic         done
`ifdef AES_SPI_MASTER_TIMEOUT_EN
  ,
  output logic         timeout
`endif
);

  // The phase counter is wide enough for every timed phase.
  localparam int unsigned MAX_A = (CLK_DIV > HOLD_CYCLES) ? CLK_DIV : HOLD_CYCLES;
  localparam int unsigned MAX_B = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_B + 1);

  typedef enum logic [3:0] {
    IDLE, SHIFT_LO, SHIFT_HI, LOAD_END, WAIT_DONE, HOLD, READ_HI, READ_LO, FINISH
  } state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [8:0]     bitcnt, bitcnt_d;
  logic [255:0]   shreg, shreg_d;
  logic [127:0]   ct_d;
  logic           sck_d, sdi_d, load_d, busy_d, valid_d;
`ifdef AES_SPI_MASTER_TIMEOUT_EN
  logic           timeout_d;
`endif

  always_comb begin
    state_d  = state;
    cnt_d    = cnt + CW'(1);
    bitcnt_d = bitcnt;
    shreg_d  = shreg;
    ct_d     = cyphertext;
`ifdef AES_SPI_MASTER_TIMEOUT_EN
    timeout_d = timeout;
`endif
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          shreg_d  = {plaintext, key};
          ct_d     = '0;
          bitcnt_d = '0;
          state_d  = SHIFT_LO;
`ifdef AES_SPI_MASTER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      SHIFT_LO: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        // The left shift keeps the next bit at shreg[255], which equals
        // indexing the captured vector with 255 - bitcnt.
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_d    = '0;
          shreg_d  = {shreg[254:0], 1'b0};
          bitcnt_d = bitcnt + 9'd1;
          state_d  = (bitcnt == 9'd255) ? LOAD_END : SHIFT_LO;
        end
      end
      LOAD_END: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done) begin
          cnt_d   = '0;
          state_d = HOLD;
        end
`ifdef AES_SPI_MASTER_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
`else
        else begin
          cnt_d = '0;
        end
`endif
      end
      HOLD: begin
        if (cnt == CW'(HOLD_CYCLES - 1)) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = READ_HI;
        end
      end
      READ_HI: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          ct_d[7'd127 - bitcnt[6:0]] = sdo;
          state_d = READ_LO;
        end
      end
      READ_LO: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (bitcnt == 9'd127) begin
            state_d = FINISH;
          end else begin
            bitcnt_d = bitcnt + 9'd1;
            state_d  = READ_HI;
          end
        end
      end
      FINISH: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // The outputs are decoded from the state being entered and then
    // registered, so they line up with the state register and do not glitch.
    sck_d   = (state_d == SHIFT_HI) || (state_d == READ_HI);
    load_d  = state_d inside {SHIFT_LO, SHIFT_HI, LOAD_END};
    sdi_d   = (state_d inside {SHIFT_LO, SHIFT_HI}) && shreg_d[255];
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      cyphertext <= '0;
      sck        <= 1'b0;
      sdi        <= 1'b0;
      load       <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
`ifdef AES_SPI_MASTER_TIMEOUT_EN
      timeout    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bitcnt     <= bitcnt_d;
      shreg      <= shreg_d;
      cyphertext <= ct_d;
      sck        <= sck_d;
      sdi        <= sdi_d;
      load       <= load_d;
      busy       <= busy_d;
      valid      <= valid_d;
`ifdef AES_SPI_MASTER_TIMEOUT_EN
      timeout    <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_spi_master.sv
// tb_aes_spi_master: randomized self-checking bench for aes_spi_master.
// The bench plays the AES slave. It computes every expected output from a
// cycle timeline measured from the accepted start.
module tb_aes_spi_master;
  localparam int unsigned CD      = 3;
  localparam int unsigned HC      = 6;
  localparam int unsigned TO      = 64;
  localparam int unsigned W       = 513 * CD + 1;   // first WAIT_DONE cycle after start
  localparam int unsigned MIN_LAT = 2316;           // 1+512*3+3+1+6+256*3+1

  localparam logic [127:0] A1_PT  = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] A1_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] A1_CT  = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] C1_CT  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0, sdo = 1'b0, done = 1'b0;
  logic [127:0] plaintext = '0, key = '0;
  logic [127:0] cyphertext;
  logic         busy, valid, sck, sdi, load;
`ifdef AES_SPI_MASTER_TIMEOUT_EN
  logic         timeout;
`endif

  int unsigned total = 0, bad = 0;

  aes_spi_master #(.CLK_DIV(CD), .HOLD_CYCLES(HC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .plaintext(plaintext), .key(key),
    .busy(busy), .valid(valid), .cyphertext(cyphertext), .sck(sck), .sdi(sdi),
    .sdo(sdo), .load(load), .done(done)
`ifdef AES_SPI_MASTER_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model state shared between the driver and the compare process.
  logic [127:0] slave_resp = '0;
  bit           lat_check  = 1'b0;
  bit           m_act = 1'b0, m_to = 1'b0;
  int unsigned  m_o = 0, m_r = 0;       // cycle offset since start, first read cycle
  logic [255:0] m_frame = '0, rx = '0;
  logic [127:0] m_ct = '0;
  int unsigned  cyc = 0, start_cyc = 0, n_wr = 0, n_rd = 0;
  logic         p_sck = 1'b0, p_load = 1'b0;

  // Compare process: advance the model at each edge, then check the outputs.
  initial begin
    int unsigned k;
    logic e_sck, e_load, e_busy, e_valid, e_sdi;
    bit sdi_chk, ct_chk;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        m_act = 0; m_o = 0; m_r = 0; m_ct = '0; m_to = 0;
        n_wr = 0; n_rd = 0; p_sck = 0; p_load = 0;
      end else if (m_act) begin
        if (m_r == 0 && m_o >= W && done) m_r = m_o + 1 + HC;
`ifdef AES_SPI_MASTER_TIMEOUT_EN
        else if (m_r == 0 && m_o == W + TO - 1) begin m_act = 0; m_to = 1; end
`endif
        if (m_act) begin
          if (m_r != 0 && m_o == m_r + 256 * CD) m_act = 0;
          else begin
            m_o++;
            if (m_r != 0 && m_o == m_r + 256 * CD) m_ct = slave_resp;
          end
        end
      end else if (start) begin
        m_act = 1; m_o = 1; m_r = 0; m_to = 0; m_ct = '0;
        m_frame = {plaintext, key}; start_cyc = cyc - 1; n_wr = 0; n_rd = 0;
      end
      #1;
      e_sck = 0; e_load = 0; e_busy = 0; e_valid = 0; e_sdi = 0; sdi_chk = 0; ct_chk = 1;
      if (m_act) begin
        e_busy = 1;
        if (m_o <= 512 * CD) begin
          k = m_o - 1;
          e_load = 1; e_sck = ((k % (2 * CD)) >= CD);
          sdi_chk = 1; e_sdi = m_frame[255 - k / (2 * CD)];
        end else if (m_o <= 513 * CD) begin
          e_load = 1;
        end else if (m_r != 0 && m_o >= m_r) begin
          if (m_o == m_r + 256 * CD) e_valid = 1;
          else begin k = m_o - m_r; e_sck = ((k % (2 * CD)) < CD); ct_chk = 0; end
        end
      end
      chk("ctrl{sck,load,busy,valid}", 256'({sck, load, busy, valid}),
          256'({e_sck, e_load, e_busy, e_valid}));
      if (sdi_chk) chk("sdi", 256'(sdi), 256'(e_sdi));
      if (ct_chk) chk("cyphertext", 256'(cyphertext), 256'(m_ct));
`ifdef AES_SPI_MASTER_TIMEOUT_EN
      chk("timeout", 256'(timeout), 256'(m_to));
`endif
      // Framing: count sck rising edges and collect sdi as the slave would.
      if (sck && !p_sck) begin
        if (load) begin
          rx = {rx[254:0], sdi}; n_wr++;
          if (n_wr == 1) chk("first_sdi_pt127", 256'(sdi), 256'(m_frame[255]));
        end else n_rd++;
      end
      if (p_load && !load) begin
        chk("load_sck_edges", 256'(n_wr), 256'(256));
        chk("load_frame", rx, m_frame);
        chk("last_sdi_key0", 256'(rx[0]), 256'(m_frame[0]));
      end
      if (valid) begin
        chk("read_sck_edges", 256'(n_rd), 256'(128));
        if (lat_check) chk("latency", 256'(cyc - start_cyc + 1), 256'(MIN_LAT));
      end
      p_sck = sck; p_load = load;
    end
  end

  // One transaction from the slave side. dly < 0 raises done before the
  // wait begins. dly >= 1000 never raises done. abort_o pulls reset low at
  // that cycle offset.
  task automatic run_txn(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] resp,
                         input int dly, input bit pulses, input int unsigned abort_o);
    int unsigned r_first, fin, last;
    bit never;
    never   = (dly >= 1000);
    r_first = W + ((dly > 0) ? unsigned'(dly) : 0) + 1 + HC;
    fin     = r_first + 256 * CD;
    last    = never ? W + TO + 2 : fin + 1;
    @(negedge clk);
    plaintext = pt; key = k; slave_resp = resp; lat_check = (dly <= 0); start = 1;
    for (int unsigned o = 1; o <= last; o++) begin
      @(negedge clk);
      start = 0; plaintext = rand128(); key = rand128();
      if (pulses && (o == 400 || o == W + 1 || o == r_first + 5)) start = 1;
      if (abort_o != 0 && o == abort_o) reset = 0;
      if (abort_o != 0 && o == abort_o + 1) begin reset = 1; done = 0; break; end
      done = !never && (int'(o) >= int'(W) + dly) && (o < fin);
      if (o >= r_first && o < fin && ((o - r_first) % (2 * CD)) < CD)
        sdo = resp[127 - (o - r_first) / (2 * CD)];
      else
        sdo = 1'($urandom_range(0, 1));
    end
    start = 0; done = 0;
  endtask

  initial begin
    reset = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 256'({sck, sdi, load, busy, valid}), 256'(0));
    chk("reset_cyphertext", 256'(cyphertext), 256'(0));
    reset = 1;

    run_txn(A1_PT, A1_KEY, A1_CT, -2, 0, 0);
    chk("fips_a1", 256'(cyphertext), 256'(A1_CT));
    chk("a1_idle_busy", 256'(busy), 256'(0));

    run_txn(C1_PT, C1_KEY, C1_CT, 5, 0, 0);
    chk("fips_c1", 256'(cyphertext), 256'(C1_CT));

    run_txn(rand128(), rand128(), {16{8'hA5}}, 0, 0, 0);
    chk("a5_pattern", 256'(cyphertext), 256'({16{8'hA5}}));

    run_txn(rand128(), rand128(), rand128(), 7, 1, 0);

    // Reset at bit 100 of the load phase, then the A.1 vector again.
    run_txn(A1_PT, A1_KEY, A1_CT, 3, 0, 1 + 2 * CD * 100);
    chk("abort_outputs", 256'({sck, load, busy, valid}), 256'(0));
    run_txn(A1_PT, A1_KEY, A1_CT, 4, 1, 0);
    chk("a1_after_abort", 256'(cyphertext), 256'(A1_CT));

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_txn(rand128(), rand128(), rand128(), int'($urandom_range(0, 23)) - 3,
              1'($urandom_range(0, 1)), 0);
    end

`ifdef AES_SPI_MASTER_TIMEOUT_EN
    run_txn(rand128(), rand128(), rand128(), 1000, 1, 0);
    chk("timeout_set", 256'(timeout), 256'(1));
    chk("timeout_busy", 256'(busy), 256'(0));
    run_txn(rand128(), rand128(), rand128(), 2, 0, 0);
    chk("timeout_cleared", 256'(timeout), 256'(0));
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
